// File: rtl/sr_arb_pkg.sv
// sr_arb_pkg: shared FSM state and op encodings for the SR flag arbiter.
package sr_arb_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;
  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;
endpackage

// File: rtl/sr_flag_arbiter_if.sv
// sr_flag_arbiter_if: requester/arbiter bundle; conflict_cnt exists only with SR_ARB_CONFLICT_CNT_EN.
interface sr_flag_arbiter_if #(
  parameter int NREQ = 4
`ifdef SR_ARB_CONFLICT_CNT_EN
  , parameter int CNT_W = 8
`endif
);
  logic [NREQ-1:0] req, op, gnt;
  logic done, busy, lat_en, lat_s, lat_r, q;
`ifdef SR_ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] conflict_cnt;
`endif
  modport master (
    output req, op,
    input gnt, done, busy, lat_en, lat_s, lat_r, q
`ifdef SR_ARB_CONFLICT_CNT_EN
    , input conflict_cnt
`endif
  );
  modport slave (
    input req, op,
    output gnt, done, busy, lat_en, lat_s, lat_r, q
`ifdef SR_ARB_CONFLICT_CNT_EN
    , output conflict_cnt
`endif
  );
endinterface

// File: rtl/sr_flag_cell.sv
// sr_flag_cell: clocked SR flag; set and reset together hold the current value.
module sr_flag_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q
);
  logic q_q, q_d;
  always_comb q_d = (en & s & ~r) ? 1'b1 : (en & r & ~s) ? 1'b0 : q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= 1'b0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbiter sequencing a shared SR flag cell.
// Optional saturating set/clear conflict counter enabled by SR_ARB_CONFLICT_CNT_EN.
module sr_flag_arbiter
  import sr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int HOLD_CYC = 2
`ifdef SR_ARB_CONFLICT_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input logic clk,
  input logic rst,
  sr_flag_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, win;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic op_q, op_d, found, cell_q, lat_en, lat_s, lat_r;
  // Downward scan so the lowest offset from the pointer is written last and wins.
  always_comb begin
    win = ptr_q;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req[PW'((int'(ptr_q) + i) % NREQ)]) begin
        win = PW'((int'(ptr_q) + i) % NREQ);
        found = 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    op_d = op_q;
    hold_d = hold_q;
    ptr_d = ptr_q;
    win_d = win_q;
    case (state_q)
      IDLE: if (found) begin
        gnt_d = NREQ'(1) << win;
        op_d = bus.op[win];
        win_d = win;
        hold_d = HW'(HOLD_CYC - 1);
        state_d = (bus.op[win] == cell_q) ? DONE : DRIVE;
      end
      DRIVE: begin
        hold_d = (hold_q == '0) ? hold_q : hold_q - HW'(1);
        state_d = (hold_q == '0) ? DONE : DRIVE;
      end
      DONE: begin
        gnt_d = '0;
        ptr_d = (int'(win_q) == NREQ - 1) ? '0 : win_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      op_q <= 1'b0;
      hold_q <= '0;
      ptr_q <= '0;
      win_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      op_q <= op_d;
      hold_q <= hold_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
    end
  assign lat_en = state_q == DRIVE;
  assign lat_s = lat_en & (op_q == OP_SET);
  assign lat_r = lat_en & (op_q == OP_CLR);
  sr_flag_cell u_cell (.clk(clk), .rst(rst), .en(lat_en), .s(lat_s), .r(lat_r), .q(cell_q));
  assign bus.gnt = gnt_q;
  assign bus.done = state_q == DONE;
  assign bus.busy = state_q != IDLE;
  assign bus.lat_en = lat_en;
  assign bus.lat_s = lat_s;
  assign bus.lat_r = lat_r;
  assign bus.q = cell_q;
`ifdef SR_ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = (state_q == IDLE && |(bus.req & bus.op) && |(bus.req & ~bus.op) && !(&cnt_q))
          ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign bus.conflict_cnt = cnt_q;
`endif
endmodule
